// File: rtl/pu_riscv_pkg.sv
// Shared RISC-V core constants: ISA width encodings (misa.MXL) and the
// machine-mode CSR address map used by the CSR state block.
package pu_riscv_pkg;

   localparam logic [1:0] RV32I = 2'b01;
   localparam logic [1:0] RV64I = 2'b10;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_CYCLE     = 12'hC00;
   localparam logic [11:0] CSR_INSTRET   = 12'hC02;
   localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
   localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

   localparam int unsigned MSTATUS_MIE  = 3;
   localparam int unsigned MSTATUS_MPIE = 7;

endpackage

// File: rtl/pu_riscv_csr_counter.sv
// 64-bit event counter with independently writable 32-bit halves.
// Any write suppresses the increment; an unwritten half holds its value.
module pu_riscv_csr_counter (
   input  logic        clk,
   input  logic        rstn,
   input  logic        inc,
   input  logic        we_lo,
   input  logic        we_hi,
   input  logic [63:0] wdata,
   output logic [63:0] count
);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count <= '0;
      end else if (we_lo || we_hi) begin
         if (we_lo) count[31:0]  <= wdata[31:0];
         if (we_hi) count[63:32] <= wdata[63:32];
      end else begin
         count <= count + 64'(inc);
      end
   end

endmodule

// File: rtl/pu_riscv_csr_state.sv
// Machine-mode CSR state: combinational read/decode for EX, write commit,
// trap entry / mret updates from WB, and the mcycle/minstret counters.
module pu_riscv_csr_state
   import pu_riscv_pkg::*;
#(
   parameter int unsigned     XLEN        = 64,
   parameter int unsigned     HAS_RVC     = 1,
   parameter logic [XLEN-1:0] MTVEC_RESET = 'h100
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            ex_stall,
   input  logic [11:0]     ex_csr_reg,
   input  logic            ex_csr_we,
   input  logic [XLEN-1:0] ex_csr_wval,
   output logic [XLEN-1:0] st_csr_rval,
   output logic            st_csr_illegal,
   output logic [1:0]      st_xlen,
   input  logic            wb_retire,
   input  logic            wb_exception,
   input  logic [XLEN-1:0] wb_epc,
   input  logic [XLEN-1:0] wb_cause,
   input  logic            wb_mret,
   output logic [XLEN-1:0] st_mtvec,
   output logic [XLEN-1:0] st_mepc,
   output logic            st_mie
);

   localparam bit IS32 = (XLEN == 32);

   logic            mie_q, mpie_q;
   logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, misa;
   logic [63:0]     mcycle, minstret, cnt_wdata;
   logic            csr_hit, csr_ro, wr_en;
   logic            cyc_we_lo, cyc_we_hi, ins_we_lo, ins_we_hi;

   function automatic logic [XLEN-1:0] epc_mask(input logic [XLEN-1:0] v);
      epc_mask    = v;
      epc_mask[0] = 1'b0;
      if (HAS_RVC == 0) epc_mask[1] = 1'b0;
   endfunction

   always_comb begin
      st_xlen = IS32 ? RV32I : RV64I;
      misa = '0;
      misa[XLEN-1 -: 2] = st_xlen;
      misa[8] = 1'b1;
      misa[2] = (HAS_RVC != 0);

      csr_hit     = 1'b1;
      csr_ro      = (ex_csr_reg[11:10] == 2'b11);
      st_csr_rval = '0;
      case (ex_csr_reg)
         CSR_MSTATUS: begin
            st_csr_rval[MSTATUS_MIE]  = mie_q;
            st_csr_rval[MSTATUS_MPIE] = mpie_q;
         end
         CSR_MISA: begin
            st_csr_rval = misa;
            csr_ro      = 1'b1;
         end
         CSR_MTVEC:                 st_csr_rval = mtvec_q;
         CSR_MSCRATCH:              st_csr_rval = mscratch_q;
         CSR_MEPC:                  st_csr_rval = mepc_q;
         CSR_MCAUSE:                st_csr_rval = mcause_q;
         CSR_MCYCLE, CSR_CYCLE:     st_csr_rval = XLEN'(mcycle);
         CSR_MINSTRET, CSR_INSTRET: st_csr_rval = XLEN'(minstret);
         CSR_MCYCLEH, CSR_CYCLEH: begin
            if (IS32) st_csr_rval = XLEN'(mcycle[63:32]);
            else      csr_hit     = 1'b0;
         end
         CSR_MINSTRETH, CSR_INSTRETH: begin
            if (IS32) st_csr_rval = XLEN'(minstret[63:32]);
            else      csr_hit     = 1'b0;
         end
         default: csr_hit = 1'b0;
      endcase

      st_csr_illegal = !csr_hit || (csr_ro && ex_csr_we);
      wr_en          = ex_csr_we && !ex_stall && !st_csr_illegal;

      // RV64 writes the whole counter through the low address; RV32 splits it.
      cnt_wdata = IS32 ? {2{ex_csr_wval[31:0]}} : 64'(ex_csr_wval);
      cyc_we_lo = wr_en && (ex_csr_reg == CSR_MCYCLE);
      cyc_we_hi = wr_en && (ex_csr_reg == (IS32 ? CSR_MCYCLEH : CSR_MCYCLE));
      ins_we_lo = wr_en && (ex_csr_reg == CSR_MINSTRET);
      ins_we_hi = wr_en && (ex_csr_reg == (IS32 ? CSR_MINSTRETH : CSR_MINSTRET));

      st_mtvec = mtvec_q;
      st_mepc  = mepc_q;
      st_mie   = mie_q;
   end

   // WB updates are issued after the CSR write so they take priority.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         mtvec_q    <= MTVEC_RESET;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
      end else begin
         if (wr_en) begin
            case (ex_csr_reg)
               CSR_MSTATUS: begin
                  mie_q  <= ex_csr_wval[MSTATUS_MIE];
                  mpie_q <= ex_csr_wval[MSTATUS_MPIE];
               end
               CSR_MTVEC:    mtvec_q    <= {ex_csr_wval[XLEN-1:2], 2'b00};
               CSR_MSCRATCH: mscratch_q <= ex_csr_wval;
               CSR_MEPC:     mepc_q     <= epc_mask(ex_csr_wval);
               CSR_MCAUSE:   mcause_q   <= ex_csr_wval;
               default: ;
            endcase
         end
         if (wb_exception) begin
            mepc_q   <= epc_mask(wb_epc);
            mcause_q <= wb_cause;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
         end else if (wb_mret) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
         end
      end
   end

   pu_riscv_csr_counter u_mcycle (
      .clk   (clk),
      .rstn  (rstn),
      .inc   (1'b1),
      .we_lo (cyc_we_lo),
      .we_hi (cyc_we_hi),
      .wdata (cnt_wdata),
      .count (mcycle)
   );

   pu_riscv_csr_counter u_minstret (
      .clk   (clk),
      .rstn  (rstn),
      .inc   (wb_retire),
      .we_lo (ins_we_lo),
      .we_hi (ins_we_hi),
      .wdata (cnt_wdata),
      .count (minstret)
   );

endmodule

// File: tb/tb_pu_riscv_csr_state.sv
// Directed bench for pu_riscv_csr_state (RV32, compressed ISA): a CSR-level
// model checked every cycle, plus literal expectations at key points.
module tb_pu_riscv_csr_state;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        ex_stall = 1'b0, ex_csr_we = 1'b0;
   logic [11:0] ex_csr_reg = 12'h000;
   logic [31:0] ex_csr_wval = '0;
   logic        wb_retire = 1'b0, wb_exception = 1'b0, wb_mret = 1'b0;
   logic [31:0] wb_epc = '0, wb_cause = '0;
   logic [31:0] st_csr_rval, st_mtvec, st_mepc;
   logic        st_csr_illegal, st_mie;
   logic [1:0]  st_xlen;

   int total = 0;
   int bad   = 0;

   // architectural model state
   logic        m_mie = 1'b0, m_mpie = 1'b0;
   logic [31:0] m_mtvec = 32'h100, m_mscratch = '0, m_mepc = '0, m_mcause = '0;
   logic [63:0] m_cyc = '0, m_ins = '0;

   pu_riscv_csr_state #(.XLEN(32), .HAS_RVC(1), .MTVEC_RESET(32'h100)) dut (
      .clk(clk), .rstn(rstn), .ex_stall(ex_stall), .ex_csr_reg(ex_csr_reg),
      .ex_csr_we(ex_csr_we), .ex_csr_wval(ex_csr_wval), .st_csr_rval(st_csr_rval),
      .st_csr_illegal(st_csr_illegal), .st_xlen(st_xlen), .wb_retire(wb_retire),
      .wb_exception(wb_exception), .wb_epc(wb_epc), .wb_cause(wb_cause),
      .wb_mret(wb_mret), .st_mtvec(st_mtvec), .st_mepc(st_mepc), .st_mie(st_mie)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic void mread(input logic [11:0] a, output bit ok, output bit ro,
                                 output logic [31:0] v);
      ok = 1'b1;
      ro = (a[11:10] == 2'b11);
      v  = '0;
      case (a)
         12'h300: v = (32'(m_mie) << 3) | (32'(m_mpie) << 7);
         12'h301: begin v = 32'h4000_0104; ro = 1'b1; end
         12'h305: v = m_mtvec;
         12'h340: v = m_mscratch;
         12'h341: v = m_mepc;
         12'h342: v = m_mcause;
         12'hB00, 12'hC00: v = m_cyc[31:0];
         12'hB80, 12'hC80: v = m_cyc[63:32];
         12'hB02, 12'hC02: v = m_ins[31:0];
         12'hB82, 12'hC82: v = m_ins[63:32];
         default: ok = 1'b0;
      endcase
   endfunction

   always @(posedge clk or negedge rstn) begin : model
      bit ok, ro, wr;
      logic [31:0] v;
      logic        n_mie, n_mpie;
      logic [31:0] n_mtvec, n_mscratch, n_mepc, n_mcause;
      logic [63:0] n_cyc, n_ins;
      if (!rstn) begin
         m_mie <= 1'b0; m_mpie <= 1'b0; m_mtvec <= 32'h100; m_mscratch <= '0;
         m_mepc <= '0; m_mcause <= '0; m_cyc <= '0; m_ins <= '0;
      end else begin
         mread(ex_csr_reg, ok, ro, v);
         wr = ex_csr_we && !ex_stall && ok && !ro;
         n_mie = m_mie; n_mpie = m_mpie; n_mtvec = m_mtvec; n_mscratch = m_mscratch;
         n_mepc = m_mepc; n_mcause = m_mcause;
         n_cyc = m_cyc + 64'd1;
         n_ins = m_ins + 64'(wb_retire);
         if (wr) begin
            case (ex_csr_reg)
               12'h300: begin n_mie = ex_csr_wval[3]; n_mpie = ex_csr_wval[7]; end
               12'h305: n_mtvec = ex_csr_wval & ~32'h3;
               12'h340: n_mscratch = ex_csr_wval;
               12'h341: n_mepc = ex_csr_wval & ~32'h1;
               12'h342: n_mcause = ex_csr_wval;
               12'hB00: n_cyc = {m_cyc[63:32], ex_csr_wval};
               12'hB80: n_cyc = {ex_csr_wval, m_cyc[31:0]};
               12'hB02: n_ins = {m_ins[63:32], ex_csr_wval};
               12'hB82: n_ins = {ex_csr_wval, m_ins[31:0]};
               default: ;
            endcase
         end
         if (wb_exception) begin
            n_mepc = wb_epc & ~32'h1; n_mcause = wb_cause; n_mpie = m_mie; n_mie = 1'b0;
         end else if (wb_mret) begin
            n_mie = m_mpie; n_mpie = 1'b1;
         end
         m_mie <= n_mie; m_mpie <= n_mpie; m_mtvec <= n_mtvec; m_mscratch <= n_mscratch;
         m_mepc <= n_mepc; m_mcause <= n_mcause; m_cyc <= n_cyc; m_ins <= n_ins;
      end
   end

   always @(negedge clk) begin : compare
      bit ok, ro;
      logic [31:0] v;
      mread(ex_csr_reg, ok, ro, v);
      chk("rval", 64'(st_csr_rval), 64'(v));
      chk("illegal", 64'(st_csr_illegal), 64'(!ok || (ro && ex_csr_we)));
      chk("st_mtvec", 64'(st_mtvec), 64'(m_mtvec));
      chk("st_mepc", 64'(st_mepc), 64'(m_mepc));
      chk("st_mie", 64'(st_mie), 64'(m_mie));
      chk("st_xlen", 64'(st_xlen), 64'd1);
   end

   task automatic cyc(input logic [11:0] a, input logic we, input logic [31:0] d,
                      input logic st);
      @(posedge clk);
      #1;
      ex_csr_reg = a; ex_csr_we = we; ex_csr_wval = d; ex_stall = st;
      wb_retire = 1'b0; wb_exception = 1'b0; wb_mret = 1'b0;
   endtask

   task automatic lit(input string nm, input logic [31:0] exp);
      @(negedge clk);
      chk(nm, 64'(st_csr_rval), 64'(exp));
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;

      cyc(12'h305, 0, 0, 0); lit("mtvec_reset", 32'h100);
      chk("mtvec_reset_ill", 64'(st_csr_illegal), 64'd0);
      cyc(12'h7C0, 0, 0, 0); lit("unimpl_rval", 32'h0);
      chk("unimpl_ill", 64'(st_csr_illegal), 64'd1);
      cyc(12'h301, 0, 0, 0); lit("misa", 32'h4000_0104);

      cyc(12'h340, 1, 32'hDEADBEEF, 1);
      cyc(12'h340, 0, 0, 0); lit("mscratch_stalled", 32'h0);
      cyc(12'h340, 1, 32'hDEADBEEF, 0);
      cyc(12'h340, 0, 0, 0); lit("mscratch_written", 32'hDEADBEEF);

      cyc(12'hC00, 1, 32'h123, 0);
      @(negedge clk) chk("cycle_ro_ill", 64'(st_csr_illegal), 64'd1);
      cyc(12'hB00, 1, 32'd5, 0);
      cyc(12'hB00, 0, 0, 0); lit("mcycle_5", 32'd5);
      cyc(12'hB00, 0, 0, 0); lit("mcycle_6", 32'd6);

      cyc(12'hB00, 1, 32'hFFFF_FFFF, 0);
      cyc(12'hB80, 1, 32'h0, 0);
      cyc(12'hB80, 0, 0, 0); lit("mcycleh_pre", 32'd0);
      cyc(12'hB80, 0, 0, 0); lit("mcycleh_carry", 32'd1);
      cyc(12'hB00, 0, 0, 0); lit("mcycle_after_carry", 32'd1);

      cyc(12'hB80, 1, 32'hFFFF_FFFF, 0);
      cyc(12'hB00, 1, 32'hFFFF_FFFE, 0);
      cyc(12'hC00, 0, 0, 0); lit("cycle_fffe", 32'hFFFF_FFFE);
      cyc(12'hC00, 0, 0, 0); lit("cycle_ffff", 32'hFFFF_FFFF);
      cyc(12'hC80, 0, 0, 0); lit("cycleh_wrap", 32'h0);

      cyc(12'hC02, 0, 0, 0); wb_retire = 1'b1;
      cyc(12'hC02, 0, 0, 0); wb_retire = 1'b1;
      cyc(12'hC02, 0, 0, 0); wb_retire = 1'b1;
      cyc(12'hC02, 0, 0, 0); lit("instret_3", 32'd3);
      cyc(12'hB82, 1, 32'd2, 0); wb_retire = 1'b1;
      cyc(12'hC82, 0, 0, 0); lit("instreth_2", 32'd2);
      cyc(12'hC02, 0, 0, 0); lit("instret_held", 32'd3);

      cyc(12'h300, 1, 32'h8, 0);
      cyc(12'h300, 0, 0, 0); lit("mstatus_mie", 32'h8);
      cyc(12'h341, 0, 0, 0); wb_exception = 1'b1; wb_epc = 32'h1003; wb_cause = 32'd2;
      cyc(12'h341, 0, 0, 0); lit("trap_mepc", 32'h1002);
      chk("trap_st_mie", 64'(st_mie), 64'd0);
      cyc(12'h342, 0, 0, 0); lit("trap_mcause", 32'd2);
      cyc(12'h300, 0, 0, 0); wb_mret = 1'b1; lit("trap_mstatus", 32'h80);
      cyc(12'h300, 0, 0, 0); lit("mret_mstatus", 32'h88);

      cyc(12'h341, 1, 32'h40, 0); wb_exception = 1'b1; wb_epc = 32'h200; wb_cause = 32'd5;
      cyc(12'h341, 0, 0, 0); lit("exc_beats_write", 32'h200);
      cyc(12'h340, 1, 32'd7, 0); wb_exception = 1'b1; wb_epc = 32'h300; wb_cause = 32'd6;
      cyc(12'h340, 0, 0, 0); lit("other_write_commits", 32'd7);

      cyc(12'h300, 1, 32'h80, 0);
      cyc(12'h300, 0, 0, 0); wb_exception = 1'b1; wb_mret = 1'b1; wb_epc = 32'h404; wb_cause = 32'd3;
      cyc(12'h300, 0, 0, 0); lit("exc_beats_mret", 32'h0);
      cyc(12'h305, 1, 32'h207, 0);
      cyc(12'h305, 0, 0, 0); lit("mtvec_low_bits", 32'h204);
      cyc(12'h301, 1, 32'h0, 0);
      @(negedge clk) chk("misa_write_ill", 64'(st_csr_illegal), 64'd1);

      cyc(12'h340, 1, 32'h55, 0);
      #2 rstn = 1'b0;
      @(negedge clk) chk("async_rst_mtvec", 64'(st_mtvec), 64'h100);
      cyc(12'h340, 0, 0, 0); rstn = 1'b1;
      lit("rst_mscratch", 32'h0);
      cyc(12'hC00, 0, 0, 0); lit("rst_cycle", 32'd1);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
